// File: rtl/fetch_aligner_if.sv
// fetch_aligner_if: INSTMEM read port, redirect/advance controls and issue outputs of fetch_aligner.
interface fetch_aligner_if #(
    parameter int PC_W = 12
);
    logic            en;
    logic            flush;
    logic [PC_W-1:0] flush_pc;
    logic [PC_W-1:0] fetch_addr;
    logic [31:0]     fetch_word;
    logic [31:0]     inst_out;
    logic [PC_W-1:0] inst_pc;
    logic [PC_W-1:0] inst_pc_next;
    logic            inst_is_comp;
    logic            inst_valid;
    logic            buffer_stall;

    modport master (
        input  en, flush, flush_pc, fetch_word,
        output fetch_addr, inst_out, inst_pc, inst_pc_next, inst_is_comp, inst_valid, buffer_stall
    );
    modport slave (
        output en, flush, flush_pc, fetch_word,
        input  fetch_addr, inst_out, inst_pc, inst_pc_next, inst_is_comp, inst_valid, buffer_stall
    );
endinterface

// File: rtl/fetch_aligner.sv
// fetch_aligner: turns word-aligned INSTMEM reads into one 16/32-bit instruction per cycle.
// Define COMPRESSED_EN for RVC halfword alignment; otherwise every word issues as a 32-bit instruction.
module fetch_aligner #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            nrst,
    fetch_aligner_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [PC_W-1:0] pc, pc_inc, step, fetch, word_addr;
    logic [31:0]     inst;
    logic            is_comp, valid, stall;

    assign word_addr = {pc[PC_W-1:2], 2'b00};
    assign pc_inc    = pc + step;

`ifdef COMPRESSED_EN
    typedef enum logic [1:0] {ALIGNED, HELD, REFILL} state_t;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc_nx;
    logic [15:0]     hold, hold_nx;
    logic            lo_comp, hold_comp, keep_hold;
    logic            unused;

    assign unused = bus.flush_pc[0];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pc    <= '0;
            hold  <= '0;
            state <= ALIGNED;
        end else begin
            pc    <= pc_nx;
            hold  <= hold_nx;
            state <= state_nx;
        end
    end

    always_comb begin
        lo_comp   = bus.fetch_word[1:0] != 2'b11;
        hold_comp = hold[1:0] != 2'b11;
        is_comp   = state == HELD ? hold_comp : state == ALIGNED && lo_comp;
        valid     = state != REFILL;
        stall     = state == REFILL;
        inst      = state == REFILL ? NOP
                  : is_comp ? {16'h0, state == HELD ? hold : bus.fetch_word[15:0]}
                  : state == HELD ? {bus.fetch_word[15:0], hold} : bus.fetch_word;
        // HELD already owns the low half of the instruction, so it reads ahead one word
        fetch     = state == HELD ? {pc[PC_W-1:2] + (PC_W-2)'(1), 2'b00} : word_addr;
        step      = !valid ? '0 : is_comp ? PC_W'(2) : PC_W'(4);
        keep_hold = (state == ALIGNED && !lo_comp) || (state == HELD && hold_comp);
        pc_nx     = pc;
        hold_nx   = hold;
        state_nx  = state;
        if (bus.flush) begin
            pc_nx    = {bus.flush_pc[PC_W-1:1], 1'b0};
            hold_nx  = '0;
            state_nx = bus.flush_pc[1] ? REFILL : ALIGNED;
        end else if (bus.en) begin
            pc_nx    = pc_inc;
            hold_nx  = keep_hold ? hold : bus.fetch_word[31:16];
            state_nx = state == HELD && hold_comp ? ALIGNED
                     : state == ALIGNED && !lo_comp ? ALIGNED : HELD;
        end
    end
`else
    logic [1:0] unused;

    assign unused = bus.flush_pc[1:0];

    always_ff @(posedge clk) begin
        if (!nrst)
            pc <= '0;
        else if (bus.flush)
            pc <= {bus.flush_pc[PC_W-1:2], 2'b00};
        else if (bus.en)
            pc <= pc_inc;
    end

    always_comb begin
        inst    = bus.fetch_word;
        is_comp = 1'b0;
        valid   = 1'b1;
        stall   = 1'b0;
        fetch   = word_addr;
        step    = PC_W'(4);
    end
`endif

    // reset forces a bubble with zeroed addresses regardless of state
    assign bus.fetch_addr   = nrst ? fetch : '0;
    assign bus.inst_out     = nrst ? inst : NOP;
    assign bus.inst_pc      = nrst ? pc : '0;
    assign bus.inst_pc_next = nrst ? pc_inc : '0;
    assign bus.inst_is_comp = nrst && is_comp;
    assign bus.inst_valid   = nrst && valid;
    assign bus.buffer_stall = nrst && stall;
endmodule

// File: doc/fetch_aligner.md
# fetch_aligner

Instruction fetch aligner between INSTMEM and the IF/ID pipeline register of the RV32IMC core. It turns the stream of word-aligned 32-bit INSTMEM reads into one instruction per cycle, either 16-bit compressed or 32-bit. It holds a leftover upper halfword so that 32-bit instructions straddling a word boundary are reassembled. It owns the IF-stage program counter and drives `buffer_stall` into the stall/flush controller.

## Interface
- `PC_W`, 12: PC and INSTMEM byte-address width; all PC arithmetic wraps modulo 2^PC_W.
- `clk`  in  1  core clock; all state updates on rising edge.
- `nrst`  in  1  reset; synchronous and active-low, one clock.
- `en`  in  1  IF advance enable (`if_clk_en`); 0 freezes all state.
- `flush`  in  1  redirect request; takes priority over `en`.
- `flush_pc`  in  PC_W  redirect target; bit 0 ignored (treated as 0).
- `fetch_addr`  out  PC_W  word-aligned INSTMEM read address (bits [1:0] = 0).
- `fetch_word`  in  32  combinational INSTMEM data for `fetch_addr`, same cycle.
- `inst_out`  out  32  issued instruction; compressed forms are zero-extended `{16'h0, half}`.
- `inst_pc`  out  PC_W  address of `inst_out`.
- `inst_pc_next`  out  PC_W  `inst_pc`+2 if compressed, else +4; feeds the pc4 path.
- `inst_is_comp`  out  1  `inst_out` is a 16-bit instruction.
- `inst_valid`  out  1  `inst_out` is a real instruction; 0 means NOP bubble.
- `buffer_stall`  out  1  aligner is refilling; IF/ID must capture a bubble.

## Operation
- Registered state:
  - `pc` (PC_W bits)
  - `hold` (16 bits)
  - `state` ∈ {ALIGNED, HELD, REFILL}
- `fetch_addr` by state:
  - ALIGNED and REFILL: `{pc[PC_W-1:2], 2'b00}`.
  - HELD: the next word address, `{pc[PC_W-1:2]+1, 2'b00}`, wrapping.
- A halfword `h` is compressed iff `h[1:0] != 2'b11`.
- ALIGNED (`pc[1]`=0), with `w` = `fetch_word`:
  - If `w[15:0]` is compressed: issue `w[15:0]`, set `pc+=2`, set `hold<=w[31:16]`, go to HELD.
  - Otherwise: issue `w`, set `pc+=4`, stay ALIGNED.
- HELD (`pc[1]`=1; `hold` is the halfword at `pc`):
  - If `hold` is compressed: issue `hold`, set `pc+=2`, go to ALIGNED. The current `fetch_word` is not consumed.
  - Otherwise: issue `{w[15:0], hold}`, set `pc+=4`, set `hold<=w[31:16]`, stay HELD.
- REFILL: set `hold<=w[31:16]` and go to HELD; `pc` is unchanged.
  - Outputs: `inst_valid`=0, `inst_out`=32'h00000013, `inst_is_comp`=0, `buffer_stall`=1.
  - `inst_pc`=`pc`, `inst_pc_next`=`pc`.
- `inst_valid`=1 and `buffer_stall`=0 in ALIGNED and HELD.
- Flush sets `pc<=flush_pc & ~1`. The next state is REFILL if `flush_pc[1]`, else ALIGNED. Any held halfword is discarded.
- Update rule:
  - `nrst`=0 beats `flush`.
  - `flush` beats `en`.
  - `en`=0 with no flush: all state holds, and combinational outputs track `fetch_word` only.
- Reset: `pc`=0, `hold`=0, `state`=ALIGNED.
  - While `nrst`=0, outputs are forced: `inst_valid`=0, `inst_out`=32'h00000013, `inst_is_comp`=0, `buffer_stall`=0, `fetch_addr`=0, `inst_pc`=0, `inst_pc_next`=0.
- Reset mid-operation (any state) has the same result. The held halfword is dropped.
- Wrap-around:
  - `pc` at `2^PC_W-2` in HELD reads word 0 as the following word.
  - `pc+4` and `pc+2` wrap silently.

## Timing
- The issue path is combinational from `fetch_word` and state to `inst_*`, with zero cycles of latency. IF/ID registers the outputs on the same edge that advances the aligner.
- Throughput is one instruction per enabled cycle.
- A flush to an aligned target: first instruction issues in the cycle after the flush edge.
- A flush to a misaligned target: one REFILL bubble cycle, then the instruction issues.
- `buffer_stall` is high for exactly one enabled cycle per misaligned redirect. If `en`=0 during REFILL, it stays high until the REFILL cycle completes under `en`=1.

## Configuration
- `COMPRESSED_EN` defined: full RVC alignment as above.
- `COMPRESSED_EN` undefined:
  - Every word is issued as 32-bit: `inst_out`=`fetch_word`, `inst_is_comp`=0, `pc+=4`.
  - `state` is fixed at ALIGNED; `hold` is not synthesised.
  - `flush_pc[1:0]` is forced to 0, and `buffer_stall` is tied to 0.

## Test plan
- Memory: 0x000=0x00A00513, 0x004=0x45854501, 0x008=0x05134501, 0x00C=0x450100A0.
- Sequential fetch: reset, then `en`=1 -> issues in order:
  - pc 0x000, 0x00A00513, next 0x004.
  - pc 0x004, 0x00004501, comp, next 0x006.
  - pc 0x006, 0x00004585, comp, next 0x008; `fetch_addr`=0x008.
  - pc 0x008, 0x00004501, comp, next 0x00A.
- Straddle: continuing from above, pc 0x00A issues 0x00A00513 with `fetch_addr`=0x00C and next 0x00E. Then pc 0x00E issues 0x00004501 (comp), next 0x010, state ALIGNED.
- Misaligned flush: `flush`=1, `flush_pc`=0x006.
  - Next cycle: `buffer_stall`=1, `inst_valid`=0, `inst_out`=0x00000013, `fetch_addr`=0x004.
  - Following cycle: pc 0x006 issues 0x00004585.
- Freeze and priority:
  - In HELD, `en`=0 for 3 cycles -> `pc` and `hold` unchanged, identical outputs each cycle.
  - `flush` with `en`=0 still redirects.
  - `flush` and `nrst`=0 together -> `pc`=0.
- Reset mid-HELD at pc 0x006 -> next cycle `pc`=0, ALIGNED, `fetch_addr`=0x000; the first issue is 0x00A00513.
- Build without `COMPRESSED_EN`: pc 0x004 issues 0x45854501 as 32-bit, next 0x008; a flush to 0x006 lands at pc 0x004 with no stall.
